kpg_carry_resolver: RTL and testbench
=====================================

KPG_CARRY_RESOLVER -- requirements
Module: kpg_carry_resolver

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; power of two, >= 2.
REQ-002 SHALL have derived constant LEVELS = log2(WIDTH), the number of prefix levels (5 for WIDTH=32).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have port in_a, input, WIDTH bits: operand A.
REQ-008 SHALL have port in_b, input, WIDTH bits: operand B.
REQ-009 SHALL have port in_cin, input, 1 bit: carry-in.
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port out_sum, output, WIDTH bits: A+B+cin, modulo 2^WIDTH.
REQ-013 SHALL have port out_cout, output, 1 bit: carry out of the MSB.
REQ-014 SHALL have port out_prop_all, output, 1 bit: every bit position propagates (a_i ^ b_i for all i).
REQ-015 SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-016 SHALL use 2-bit carry-status codes: 00 kill, 11 generate, 01/10 propagate.
REQ-017 SHALL use the combine operator C = (hi==00 || hi==11) ? hi : lo.
REQ-018 SHALL implement FSM states IDLE, RESOLVE, DONE.
REQ-019 SHALL drive in_ready = (state==IDLE), so in_ready is combinational from state only.
REQ-020 SHALL, in IDLE on in_valid && in_ready, register operands and encode per-bit codes as code[i] = {a_i, b_i}.
REQ-021 SHALL, at that same load, replace code[0] with combine(code[0], cin ? 11 : 00), set lvl=0, and go to RESOLVE.
REQ-022 SHALL, in each RESOLVE cycle with span s = 2^lvl, update code[i] = combine(code[i], code[i-s]) for i >= s, using pre-update values (Kogge-Stone level).
REQ-023 SHALL leave code[i] unchanged for i < s in that RESOLVE cycle.
REQ-024 SHALL increment lvl after each RESOLVE cycle and go to DONE after the cycle with lvl == LEVELS-1.
REQ-025 SHALL have, on entering DONE, every code equal to 00 or 11 (code[i][1] = carry out of bit i).
REQ-026 SHALL compute out_sum[i] = a_i ^ b_i ^ c_i, where c_0 = cin and c_i = code[i-1][1].
REQ-027 SHALL drive out_cout = code[WIDTH-1][1] and out_prop_all = &(a ^ b), from registered operands.
REQ-028 SHALL assert out_valid in DONE only.
REQ-029 SHALL have latency of exactly LEVELS+1 rising edges from the acceptance edge to the first cycle with out_valid high (6 for WIDTH=32).
REQ-030 SHALL hold out_sum, out_cout and out_prop_all stable while out_valid && !out_ready; the state remains DONE.
REQ-031 SHALL, on out_valid && out_ready, go to IDLE; in_ready rises the next cycle, with no same-cycle reload.
REQ-032 SHALL give throughput of one operation per LEVELS+2 cycles at best.
REQ-033 SHALL ignore in_valid outside IDLE; operands are not latched.
REQ-034 SHALL not care about out_ready outside DONE.
REQ-035 SHALL, when all bits propagate, produce out_cout = cin and out_sum = all-ones when cin=0, all-zeros when cin=1.
REQ-036 SHALL drop the carry beyond the MSB from out_sum; it appears only in out_cout.

Reset
REQ-037 SHALL, with rst high at a rising edge, force state=IDLE, lvl=0, and code/operand registers to 0.
REQ-038 SHALL produce out_valid=0, busy=0, in_ready=1, out_sum=0, out_cout=0 and out_prop_all=0 the cycle after reset.
REQ-039 SHALL, on reset during RESOLVE or DONE, abandon the operation with no output produced; rst has priority over every handshake.
REQ-040 SHALL come out of reset without needing a clock after rst deasserts: in_ready is 1 in the first cycle with rst=0.

Verification
REQ-041 SHALL cover: a=0xFFFFFFFF, b=0x00000000, cin=1 -> out_sum=0x00000000, out_cout=1, out_prop_all=1, out_valid exactly 6 edges after acceptance.
REQ-042 SHALL cover: a=0x12345678, b=0x9ABCDEF0, cin=0 -> out_sum=0xACF13568, out_cout=0, out_prop_all=0.
REQ-043 SHALL cover: a=0x80000000, b=0x80000000, cin=0 -> out_sum=0x00000000, out_cout=1; and a=b=0xFFFFFFFF, cin=1 -> out_sum=0xFFFFFFFF, out_cout=1.
REQ-044 SHALL cover: out_ready held low 3 cycles in DONE with in_valid=1 and new operands applied -> outputs unchanged, in_ready=0, and the second operand pair is accepted only after the return to IDLE.
REQ-045 SHALL cover: rst pulsed at RESOLVE lvl=2 -> next cycle in_ready=1, busy=0, out_valid=0, and no result is ever emitted for that operation.
REQ-046 SHALL cover: 1000 random operand/cin sets with random out_ready stalls -> every result matches a reference A+B+cin, with out_cout checked.

Source files
------------

// File: rtl/kpg_carry_resolver.sv
// kpg_carry_resolver: WIDTH-bit adder that resolves carries one Kogge-Stone level per cycle over 2-bit kill/propagate/generate codes, with valid/ready handshakes
module kpg_carry_resolver #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_prop_all,
  output logic             busy
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int LVW = $clog2(LEVELS) + 1;
  typedef enum logic [1:0] {IDLE, RESOLVE, DONE} state_t;
  state_t state_q, state_d;
  logic [LVW-1:0] lvl_q, lvl_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, carry;
  logic cin_q, cin_d;
  logic [WIDTH-1:0][1:0] code_q, code_d, res;
  function automatic logic [1:0] kpg(input logic [1:0] hi, input logic [1:0] lo);
    return (hi == 2'b00 || hi == 2'b11) ? hi : lo;
  endfunction
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [LEVELS-1:0][1:0] cand;
    logic [1:0] r;
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      if (i >= (1 << k)) begin : g_cmb
        assign cand[k] = kpg(code_q[i], code_q[i-(1<<k)]);
      end else begin : g_hold
        assign cand[k] = code_q[i];
      end
    end
    always_comb begin
      r = code_q[i];
      for (int k = 0; k < LEVELS; k++) r = (lvl_q == LVW'(k)) ? cand[k] : r;
    end
    assign res[i] = r;
  end
  always_comb begin
    state_d = state_q;
    lvl_d = lvl_q;
    a_d = a_q;
    b_d = b_q;
    cin_d = cin_q;
    code_d = code_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RESOLVE;
      lvl_d = '0;
      a_d = in_a;
      b_d = in_b;
      cin_d = in_cin;
      for (int i = 0; i < WIDTH; i++) code_d[i] = {in_a[i], in_b[i]};
      code_d[0] = kpg({in_a[0], in_b[0]}, {2{in_cin}});
    end else if (state_q == RESOLVE) begin
      code_d = res;
      lvl_d = lvl_q + LVW'(1);
      state_d = (lvl_q == LVW'(LEVELS - 1)) ? DONE : RESOLVE;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lvl_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      code_q <= '0;
    end else begin
      state_q <= state_d;
      lvl_q <= lvl_d;
      a_q <= a_d;
      b_q <= b_d;
      cin_q <= cin_d;
      code_q <= code_d;
    end
  end
  always_comb begin
    carry[0] = cin_q;
    for (int i = 1; i < WIDTH; i++) carry[i] = code_q[i-1][1];
  end
  assign out_sum = a_q ^ b_q ^ carry;
  assign out_cout = code_q[WIDTH-1][1];
  assign out_prop_all = &(a_q ^ b_q);
  assign out_valid = state_q == DONE;
  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_kpg_carry_resolver.sv
// tb_kpg_carry_resolver: scoreboard bench with randomized operands and an arithmetic reference model
module tb_kpg_carry_resolver;
  localparam int W = 32;
  localparam int LEVELS = $clog2(W);
  logic clk = 0, rst = 1, in_valid = 0, in_cin = 0, out_ready = 0;
  logic [W-1:0] in_a = '0, in_b = '0, out_sum;
  logic in_ready, out_valid, out_cout, out_prop_all, busy;
  typedef struct {logic [W-1:0] sum; logic cout; logic prop; int acc;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0, cyc = 0, rdy_mode = 0;
  logic prev_valid = 0;
  kpg_carry_resolver #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .out_prop_all(out_prop_all), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        if (!prev_valid) chk("latency", 64'(cyc - sb[0].acc + 1), 64'(LEVELS + 1));
        if (out_ready) begin
          mon_e = sb.pop_front();
          chk("sum", 64'(out_sum), 64'(mon_e.sum));
          chk("cout", 64'(out_cout), 64'(mon_e.cout));
          chk("prop_all", 64'(out_prop_all), 64'(mon_e.prop));
        end
      end
    end
    prev_valid <= out_valid;
  end
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W-1:0] es, input logic ec, input logic ep);
    int n = 0;
    @(negedge clk);
    in_valid = 1;
    in_a = a;
    in_b = b;
    in_cin = c;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    sb.push_back('{es, ec, ep, cyc + 1});
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic send_rand();
    logic [W-1:0] a, b;
    logic c;
    logic [W:0] full;
    a = $urandom;
    b = ($urandom_range(0, 7) == 0) ? ~a : $urandom;
    c = 1'($urandom_range(0, 1));
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    send(a, b, c, full[W-1:0], full[W], &(a ^ b));
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 0);
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_sum", 64'(out_sum), 0);
    chk("rst_out_cout", 64'(out_cout), 0);
    chk("rst_out_prop_all", 64'(out_prop_all), 0);
    send(32'hFFFFFFFF, 32'h00000000, 1, 32'h00000000, 1, 1);
    send(32'h12345678, 32'h9ABCDEF0, 0, 32'hACF13568, 0, 0);
    send(32'h80000000, 32'h80000000, 0, 32'h00000000, 1, 0);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1, 0);
    send(32'h0F0F0F0F, 32'hF0F0F0F0, 0, 32'hFFFFFFFF, 0, 1);
    drain();
    rdy_mode = 2;
    send(32'h0000FFFF, 32'h00000001, 0, 32'h00010000, 0, 0);
    in_valid = 1;
    in_a = 32'hAAAAAAAA;
    in_b = 32'h55555555;
    in_cin = 1;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_done", 64'(out_valid), 1);
    repeat (3) begin
      chk("stall_sum", 64'(out_sum), 64'h00010000);
      chk("stall_cout", 64'(out_cout), 0);
      chk("stall_prop", 64'(out_prop_all), 0);
      chk("stall_in_ready", 64'(in_ready), 0);
      chk("stall_valid", 64'(out_valid), 1);
      @(negedge clk);
    end
    rdy_mode = 0;
    send(32'hAAAAAAAA, 32'h55555555, 1, 32'h00000000, 1, 1);
    drain();
    send(32'h01234567, 32'h89ABCDEF, 1, 32'h8ACF1357, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 1);
    rst = 1;
    sb.delete();
    @(negedge clk);
    rst = 0;
    chk("abort_in_ready", 64'(in_ready), 1);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_out_valid", 64'(out_valid), 0);
    repeat (20) @(negedge clk);
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) send_rand();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
